rtc_read_capture: RTL

- Consumes the multiplexed RTC bus strobes (RD, CS, AD_o) and the sequencer's register-index code (state) produced by the RTC read sequencer.
- During each read strobe, samples the RTC data bus and files the byte into a shadow register selected by the index.
- Once a full sweep (seconds through timer-seconds) has been captured, publishes all time/date/timer bytes atomically with a one-cycle frame_valid pulse for the display/control logic.

---
 rtl/rtc_read_capture.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/rtc_read_capture.sv
`default_nettype none
// ============================================================================
// Module   : rtc_read_capture
// Purpose  : Samples RTC data during read strobes, files each byte into a
//            shadow register selected by the sequencer index, and publishes
//            a complete time/date/timer frame atomically with frame_valid.
// Revision : 1.0 - initial release
// ============================================================================
module rtc_read_capture #(
  parameter int MIN_WIN = 4,
  parameter int DW      = 8
) (
  input  logic          clk_i,
  input  logic          reset,
  input  logic          enable,
  input  logic [3:0]    state_i,
  input  logic          RD,
  input  logic          CS,
  input  logic          AD_o,
  input  logic [DW-1:0] dato_i,
  output logic [DW-1:0] status_o,
  output logic [DW-1:0] seg_o,
  output logic [DW-1:0] min_o,
  output logic [DW-1:0] hora_o,
  output logic [DW-1:0] fecha_o,
  output logic [DW-1:0] mes_o,
  output logic [DW-1:0] anio_o,
  output logic [DW-1:0] thora_o,
  output logic [DW-1:0] tmin_o,
  output logic [DW-1:0] tseg_o,
  output logic          frame_valid,
  output logic          bcd_err,
  output logic          short_err
);

  localparam logic [3:0] CNT_MAX   = 4'd15;
  localparam logic [3:0] MIN_WIN_C = 4'(MIN_WIN);

  logic                 win_q, win_d;
  logic [3:0]           win_cnt_q, win_cnt_d;
  logic [DW-1:0]        data_q, data_d;
  logic [9:1]           mask_q, mask_d;
  logic                 pub_req_q, pub_req_d;
  logic [9:1][DW-1:0]   shadow_q;

  logic win_open, win_end, win_abort, commit, short_hit, bad_any;

  // True when any nibble of the byte exceeds 9 (not valid BCD).
  function automatic logic nib_bad(input logic [DW-1:0] b);
    nib_bad = 1'b0;
    for (int i = 0; i < DW / 4; i++) begin
      if (b[i*4 +: 4] > 4'd9) nib_bad = 1'b1;
    end
  endfunction

  // Window tracking: open, accumulate samples/length, close or abort.
  always_comb begin
    win_open  = !RD && !CS && AD_o;
    win_end   = win_q && RD;
    win_abort = win_q && !RD && (CS || !AD_o);
    commit    = win_end && (win_cnt_q >= MIN_WIN_C);
    short_hit = win_end && !commit;
    win_d     = win_q;
    win_cnt_d = win_cnt_q;
    data_d    = data_q;
    if (win_end || win_abort) begin
      win_d     = 1'b0;
      win_cnt_d = 4'd0;
    end else if (win_open) begin
      win_d  = 1'b1;
      data_d = dato_i;
      if (win_cnt_q != CNT_MAX) win_cnt_d = win_cnt_q + 4'd1;
    end
  end

  // Capture mask and publish request; index 9 closes a sweep.
  always_comb begin
    mask_d    = mask_q;
    pub_req_d = 1'b0;
    if (pub_req_q) mask_d = '0;
    if (commit) begin
      for (int i = 1; i <= 9; i++) begin
        if (state_i == 4'(i)) mask_d[i] = 1'b1;
      end
      if (state_i == 4'd9) begin
        if (&mask_q[8:1]) pub_req_d = 1'b1;
        else              mask_d    = '0;
      end
    end
  end

  // BCD check over the shadow set that is about to be published.
  always_comb begin
    bad_any = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      bad_any = bad_any | nib_bad(shadow_q[i]);
    end
  end

  // State, shadows and published outputs; enable=0 freezes everything.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      win_q     <= 1'b0;
      win_cnt_q <= 4'd0;
      data_q    <= '0;
      mask_q    <= '0;
      pub_req_q <= 1'b0;
      shadow_q  <= '0;
      status_o  <= '0;
      seg_o     <= '0;
      min_o     <= '0;
      hora_o    <= '0;
      fecha_o   <= '0;
      mes_o     <= '0;
      anio_o    <= '0;
      thora_o   <= '0;
      tmin_o    <= '0;
      tseg_o    <= '0;
      bcd_err   <= 1'b0;
      short_err <= 1'b0;
    end else if (enable) begin
      win_q     <= win_d;
      win_cnt_q <= win_cnt_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
      pub_req_q <= pub_req_d;
      if (short_hit) short_err <= 1'b1;
      if (commit && state_i == 4'd0) status_o <= data_q;
      for (int i = 1; i <= 9; i++) begin
        if (commit && state_i == 4'(i)) shadow_q[i] <= data_q;
      end
      if (pub_req_q) begin
        seg_o   <= shadow_q[1];
        min_o   <= shadow_q[2];
        hora_o  <= shadow_q[3];
        fecha_o <= shadow_q[4];
        mes_o   <= shadow_q[5];
        anio_o  <= shadow_q[6];
        thora_o <= shadow_q[7];
        tmin_o  <= shadow_q[8];
        tseg_o  <= shadow_q[9];
        bcd_err <= bad_any;
      end
    end
  end

  // One-cycle frame strobe, never stretched by a freeze.
  always_ff @(posedge clk_i) begin
    if (reset) frame_valid <= 1'b0;
    else       frame_valid <= enable && pub_req_q;
  end

endmodule
`default_nettype wire
